// File: rtl/div_pkg.sv
// Shared types and op encodings for the sequential RISC-V M-extension divider.
package div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      CALC = 2'd2,
      FIX  = 2'd3
   } state_t;

   localparam logic [1:0] OP_DIV  = 2'b00;
   localparam logic [1:0] OP_DIVU = 2'b01;
   localparam logic [1:0] OP_REM  = 2'b10;
   localparam logic [1:0] OP_REMU = 2'b11;

   function automatic logic op_is_signed(input logic [1:0] op);
      return ~op[0];
   endfunction

   function automatic logic op_is_rem(input logic [1:0] op);
      return op[1];
   endfunction

endpackage

// File: rtl/nb_twos_comp.sv
// Two's complement sign changer: y = -a modulo 2^n.
module nb_twos_comp #(
   parameter int n = 32
) (
   input  logic [n-1:0] a,
   output logic [n-1:0] y
);

   assign y = '0 - a;

endmodule

// File: rtl/nb_seq_signed_div.sv
// Restoring iterative divider for DIV/DIVU/REM/REMU with fixed n+2 cycle latency.
module nb_seq_signed_div
   import div_pkg::*;
#(
   parameter int n = 32
) (
   input  logic         CLK,
   input  logic         RST_N,
   input  logic         start,
   input  logic [1:0]   op,
   input  logic [n-1:0] dividend,
   input  logic [n-1:0] divisor,
   output logic         busy,
   output logic         done,
   output logic [n-1:0] result
);

   localparam int CW = $clog2(n) + 1;
   localparam logic [CW-1:0] LAST = CW'(n - 1);

   state_t state, state_nxt;
   logic   accept;

   logic [1:0]    op_r;
   logic [n-1:0]  a_r, b_r;
   logic [n-1:0]  dmag, quo, rem;
   logic [CW-1:0] cnt;
   logic          q_neg, r_neg;

   logic          sgn;
   logic [n-1:0]  a_inv, b_inv, q_inv, r_inv;
   logic [n:0]    rem_sh, diff;
   logic [n-1:0]  quo_sh;
   logic          div0, ovf;
   logic [n-1:0]  q_fix, r_fix, res_fix;

   assign sgn = op_is_signed(op_r);

   nb_twos_comp #(.n(n)) u_tc_dividend (.a(a_r),  .y(a_inv));
   nb_twos_comp #(.n(n)) u_tc_divisor  (.a(b_r),  .y(b_inv));
   nb_twos_comp #(.n(n)) u_tc_quo      (.a(quo),  .y(q_inv));
   nb_twos_comp #(.n(n)) u_tc_rem      (.a(rem),  .y(r_inv));

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) state <= IDLE;
      else        state <= state_nxt;
   end

   // A start in the done cycle is refused so the pipeline sees one clean idle cycle.
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      case (state)
         IDLE: begin
            if (start && !done) begin
               accept    = 1'b1;
               state_nxt = LOAD;
            end
         end
         LOAD:    state_nxt = CALC;
         CALC:    if (cnt == LAST) state_nxt = FIX;
         FIX:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Remainder stays below the divisor magnitude, so n stored bits suffice;
   // the extra bit only exists in the shifted trial value.
   always_comb begin
      rem_sh = {rem, quo[n-1]};
      quo_sh = {quo[n-2:0], 1'b0};
      diff   = rem_sh - {1'b0, dmag};
   end

   always_comb begin
      div0 = (b_r == '0);
      ovf  = sgn && (a_r == {1'b1, {(n-1){1'b0}}}) && (b_r == '1);
      if (div0) begin
         q_fix = '1;
         r_fix = a_r;
      end else if (ovf) begin
         q_fix = a_r;
         r_fix = '0;
      end else begin
         q_fix = q_neg ? q_inv : quo;
         r_fix = r_neg ? r_inv : rem;
      end
      res_fix = op_is_rem(op_r) ? r_fix : q_fix;
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         op_r   <= '0;
         a_r    <= '0;
         b_r    <= '0;
         dmag   <= '0;
         quo    <= '0;
         rem    <= '0;
         cnt    <= '0;
         q_neg  <= 1'b0;
         r_neg  <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
         result <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  op_r <= op;
                  a_r  <= dividend;
                  b_r  <= divisor;
                  busy <= 1'b1;
               end else if (done) begin
                  busy <= 1'b0;
               end
            end
            LOAD: begin
               quo   <= (sgn && a_r[n-1]) ? a_inv : a_r;
               dmag  <= (sgn && b_r[n-1]) ? b_inv : b_r;
               q_neg <= sgn && (a_r[n-1] ^ b_r[n-1]);
               r_neg <= sgn && a_r[n-1];
               rem   <= '0;
               cnt   <= '0;
            end
            CALC: begin
               rem <= diff[n] ? rem_sh[n-1:0] : diff[n-1:0];
               quo <= {quo_sh[n-1:1], ~diff[n]};
               cnt <= cnt + CW'(1);
            end
            FIX: begin
               result <= res_fix;
               done   <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_nb_seq_signed_div.sv
// Scoreboard bench for nb_seq_signed_div (n=32) with a plain-arithmetic reference model.
module tb_nb_seq_signed_div;

   localparam int N   = 32;
   localparam int LAT = N + 2;

   logic          CLK = 1'b0;
   logic          RST_N = 1'b0;
   logic          start = 1'b0;
   logic [1:0]    op = '0;
   logic [N-1:0]  dividend = '0;
   logic [N-1:0]  divisor = '0;
   logic          busy, done;
   logic [N-1:0]  result;

   nb_seq_signed_div #(.n(N)) dut (
      .CLK(CLK), .RST_N(RST_N), .start(start), .op(op),
      .dividend(dividend), .divisor(divisor),
      .busy(busy), .done(done), .result(result)
   );

   always #5 CLK = ~CLK;

   int unsigned cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   typedef struct {
      logic [N-1:0] exp;
      int unsigned  acc;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, want, $time);
      end
   endtask

   // RISC-V M semantics using 64-bit arithmetic, so MIN/-1 needs no special case.
   function automatic logic [N-1:0] model(input logic [1:0] o, input logic [N-1:0] a, input logic [N-1:0] b);
      longint sa = longint'($signed(a));
      longint sd = longint'($signed(b));
      if (b == '0) return o[1] ? a : '1;
      case (o)
         2'b00:   return N'(sa / sd);
         2'b01:   return a / b;
         2'b10:   return N'(sa % sd);
         default: return a % b;
      endcase
   endfunction

   // Monitor: samples 1 time unit after each rising edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge CLK);
         #1;
         if (!RST_N) begin
            chk("rst_busy", {63'd0, busy}, 64'd0);
            chk("rst_done", {63'd0, done}, 64'd0);
            chk("rst_result", {32'd0, result}, 64'd0);
         end else if (exp_q.size() == 0) begin
            chk("idle_busy", {63'd0, busy}, 64'd0);
            chk("spurious_done", {63'd0, done}, 64'd0);
         end else begin
            e = exp_q[0];
            if (cyc >= e.acc) chk("busy_inflight", {63'd0, busy}, 64'd1);
            if (done) begin
               chk("latency", {32'd0, cyc - e.acc}, 64'(LAT));
               chk("result", {32'd0, result}, {32'd0, e.exp});
               void'(exp_q.pop_front());
            end else if (cyc >= e.acc + LAT) begin
               chk("done_missing", {63'd0, done}, 64'd1);
               void'(exp_q.pop_front());
            end
         end
      end
   end

   task automatic wait_idle();
      int g = 0;
      while ((busy || done) && g < 200) begin
         @(negedge CLK);
         g++;
      end
      if (g >= 200) begin
         total++;
         bad++;
         $display("FAIL wait_idle: busy=%0b done=%0b after %0d cycles", busy, done, g);
      end
   endtask

   task automatic issue(input logic [1:0] o, input logic [N-1:0] a, input logic [N-1:0] b);
      wait_idle();
      start    = 1'b1;
      op       = o;
      dividend = a;
      divisor  = b;
      exp_q.push_back('{exp: model(o, a, b), acc: cyc + 1});
      @(negedge CLK);
      start    = 1'b0;
      op       = 2'($urandom);
      dividend = $urandom;
      divisor  = $urandom;
   endtask

   task automatic drain();
      int g = 0;
      while (exp_q.size() != 0 && g < 200) begin
         @(negedge CLK);
         g++;
      end
      if (g >= 200) begin
         total++;
         bad++;
         $display("FAIL drain: %0d results outstanding", exp_q.size());
      end
      @(negedge CLK);
   endtask

   function automatic logic [N-1:0] pick(input bit allow_zero);
      case ($urandom_range(0, 9))
         0:       return allow_zero ? '0 : 32'd3;
         1:       return 32'h8000_0000;
         2:       return '1;
         3:       return 32'd1;
         4:       return 32'($urandom_range(0, 20));
         5:       return '0 - 32'($urandom_range(1, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int g;
      #1;
      chk("reset_busy", {63'd0, busy}, 64'd0);
      chk("reset_done", {63'd0, done}, 64'd0);
      chk("reset_result", {32'd0, result}, 64'd0);
      repeat (3) @(negedge CLK);
      RST_N = 1'b1;
      @(negedge CLK);

      issue(2'b00, 32'd7, 32'd2);
      issue(2'b00, 32'hFFFF_FFF9, 32'd2);
      issue(2'b10, 32'hFFFF_FFF9, 32'd2);
      issue(2'b10, 32'd7, 32'hFFFF_FFFE);
      issue(2'b11, 32'hFFFF_FFFF, 32'd2);
      issue(2'b01, 32'hFFFF_FFFF, 32'd2);
      issue(2'b00, 32'd5, 32'd0);
      issue(2'b10, 32'd5, 32'd0);
      issue(2'b01, 32'd5, 32'd0);
      issue(2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
      issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
      issue(2'b01, 32'h8000_0000, 32'hFFFF_FFFF);
      drain();

      // Starts while busy and in the done cycle are ignored.
      issue(2'b00, 32'd100, 32'd7);
      repeat (9) @(negedge CLK);
      start = 1'b1; op = 2'b00; dividend = 32'd1; divisor = 32'd1;
      @(negedge CLK);
      start = 1'b0;
      g = 0;
      while (!done && g < 100) begin
         @(negedge CLK);
         g++;
      end
      start = 1'b1; op = 2'b10; dividend = 32'd100; divisor = 32'd7;
      @(negedge CLK);
      exp_q.push_back('{exp: model(2'b10, 32'd100, 32'd7), acc: cyc + 1});
      @(negedge CLK);
      start = 1'b0;
      drain();

      // Reset mid-operation abandons the computation.
      issue(2'b00, 32'd100, 32'd7);
      repeat (14) @(negedge CLK);
      RST_N = 1'b0;
      exp_q.delete();
      #1;
      chk("abort_busy", {63'd0, busy}, 64'd0);
      chk("abort_done", {63'd0, done}, 64'd0);
      chk("abort_result", {32'd0, result}, 64'd0);
      @(negedge CLK);
      @(negedge CLK);
      RST_N = 1'b1;
      repeat (40) @(negedge CLK);
      issue(2'b00, 32'd9, 32'd3);
      drain();

      // Randomized traffic with occasional ignored starts mid-flight.
      for (int i = 0; i < 150; i++) begin
         issue(2'($urandom_range(0, 3)), pick(1'b0), pick(1'b1));
         if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 30)) @(negedge CLK);
            if (busy && !done) begin
               start = 1'b1; op = 2'($urandom); dividend = $urandom; divisor = $urandom;
               @(negedge CLK);
               start = 1'b0;
            end
         end
      end
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
